kl8e_fifo_console: RTL and testbench

//  Buffered KL8E console interface: decodes keyboard/printer IOTs for two device codes.

---
 rtl/kl8e_fifo_console.sv | 190 +++++++++++++++++++
 tb/tb_kl8e_fifo_console.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kl8e_fifo_console.sv
`default_nettype none
// ============================================================================
//  Module      : kl8e_fifo_console
//  Description : Buffered KL8E console. Decodes keyboard and printer IOTs for
//                two configurable device codes and places RX/TX byte FIFOs
//                between the CPU and an external UART byte core.
//  Revision    : 1.0  initial release
// ============================================================================
module kl8e_fifo_console #(
  parameter logic [5:0] KBD_DEV  = 6'o03,
  parameter logic [5:0] TTY_DEV  = 6'o04,
  parameter int         RX_DEPTH = 8,
  parameter int         TX_DEPTH = 8,
  parameter logic [4:0] F1_STATE = 5'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:11] instruction,
  input  logic [4:0]  state,
  input  logic [0:11] ac,
  input  logic        UF,
  input  logic        clear,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [0:11] serial_bus,
  output logic        ac_clear,
  output logic        skip,
  output logic        interrupt,
  output logic        rx_overrun
);

  localparam int c_RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int c_TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int c_RX_CW = c_RX_AW + 1;
  localparam int c_TX_CW = c_TX_AW + 1;
  localparam logic [c_RX_CW-1:0] c_RX_FULL = c_RX_CW'(RX_DEPTH);
  localparam logic [c_TX_CW-1:0] c_TX_FULL = c_TX_CW'(TX_DEPTH);

  // FIFO storage and pointers
  logic [7:0]         r_rx_mem [RX_DEPTH];
  logic [c_RX_AW-1:0] r_rx_rd, r_rx_wr;
  logic [c_RX_CW-1:0] r_rx_count;
  logic [7:0]         r_tx_mem [TX_DEPTH];
  logic [c_TX_AW-1:0] r_tx_rd, r_tx_wr;
  logic [c_TX_CW-1:0] r_tx_count;

  // Console state
  logic        r_tx_flag, r_int_ena, r_tx_pend;
  logic [0:11] r_serial_bus;
  logic        r_ac_clear, r_skip, r_interrupt, r_rx_overrun;

  // Decode
  logic       w_f1, w_iot, w_kbd, w_tty, w_caf;
  logic [5:0] w_dev;
  logic [2:0] w_op;
  logic       w_kbd_flag, w_rx_full, w_tx_full;
  logic       w_rx_pop, w_rx_push, w_rx_drop, w_rx_flush, w_rx_read;
  logic [7:0] w_rx_head;
  logic       w_tx_deq, w_tx_push, w_tx_pend_nxt;
  logic [c_TX_CW-1:0] w_tx_count_nxt;
  logic       w_skip_cond, w_tx_set, w_tx_clr;
  logic       w_unused;

  assign w_unused   = ^ac[0:3];
  assign w_dev      = instruction[3:8];
  assign w_op       = instruction[9:11];
  assign w_f1       = (state == F1_STATE);
  assign w_iot      = w_f1 & ~UF & (instruction[0:2] == 3'o6);
  assign w_kbd      = w_iot & ~clear & (w_dev == KBD_DEV);
  assign w_tty      = w_iot & ~clear & (w_dev == TTY_DEV);
  assign w_caf      = w_iot & ~clear & (instruction == 12'o6007);

  assign w_kbd_flag = (r_rx_count != '0);
  assign w_rx_full  = (r_rx_count == c_RX_FULL);
  assign w_tx_full  = (r_tx_count == c_TX_FULL);
  assign w_rx_head  = w_kbd_flag ? r_rx_mem[r_rx_rd] : 8'h00;

  // Pops are ignored on an empty FIFO; a full FIFO still takes a byte when
  // the same cycle pops one.
  assign w_rx_flush = clear | w_caf;
  assign w_rx_read  = w_kbd & ((w_op == 3'd4) | (w_op == 3'd6));
  assign w_rx_pop   = w_kbd & ~w_caf & w_kbd_flag &
                      ((w_op == 3'd0) | (w_op == 3'd2) | (w_op == 3'd6));
  assign w_rx_push  = ~w_rx_flush & rx_valid & (~w_rx_full | w_rx_pop);
  assign w_rx_drop  = ~w_rx_flush & rx_valid & w_rx_full & ~w_rx_pop;

  assign tx_valid   = (r_tx_count != '0);
  assign tx_data    = r_tx_mem[r_tx_rd];
  assign w_tx_deq   = tx_valid & tx_ready & ~clear;
  assign w_tx_push  = w_tty & ((w_op == 3'd4) | (w_op == 3'd6)) & (~w_tx_full | w_tx_deq);

  assign w_skip_cond = (w_kbd & (w_op == 3'd1) & w_kbd_flag) |
                       (w_tty & (w_op == 3'd1) & r_tx_flag) |
                       (w_tty & (w_op == 3'd5) & r_int_ena & (w_kbd_flag | r_tx_flag));
  assign w_tx_set    = w_tx_deq | r_tx_pend | w_caf | (w_tty & (w_op == 3'd0));
  assign w_tx_clr    = w_tty & ((w_op == 3'd2) | (w_op == 3'd6));

  // Occupancy after this cycle's push/dequeue decides whether tx_flag re-arms
  always_comb begin
    w_tx_count_nxt = r_tx_count;
    if (w_tx_push & ~w_tx_deq)      w_tx_count_nxt = r_tx_count + 1'b1;
    else if (~w_tx_push & w_tx_deq) w_tx_count_nxt = r_tx_count - 1'b1;
    w_tx_pend_nxt = w_tx_push & (w_tx_count_nxt != c_TX_FULL);
  end

  // RX FIFO data storage
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
  end

  // TX FIFO data storage
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= ac[4:11];
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_rd    <= '0;
      r_rx_wr    <= '0;
      r_rx_count <= '0;
    end else if (w_rx_flush) begin
      r_rx_rd    <= '0;
      r_rx_wr    <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      if (w_rx_push & ~w_rx_pop)      r_rx_count <= r_rx_count + 1'b1;
      else if (~w_rx_push & w_rx_pop) r_rx_count <= r_rx_count - 1'b1;
    end
  end

  // TX FIFO pointers and occupancy; CAF leaves TX draining, clear flushes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_rd    <= '0;
      r_tx_wr    <= '0;
      r_tx_count <= '0;
    end else if (clear) begin
      r_tx_rd    <= '0;
      r_tx_wr    <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_deq)  r_tx_rd <= r_tx_rd + 1'b1;
      r_tx_count <= w_tx_count_nxt;
    end
  end

  // Console flags, CPU-facing registers and interrupt request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_flag    <= 1'b1;
      r_int_ena    <= 1'b1;
      r_tx_pend    <= 1'b0;
      r_serial_bus <= '0;
      r_ac_clear   <= 1'b0;
      r_skip       <= 1'b0;
      r_interrupt  <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_interrupt <= r_int_ena & (w_kbd_flag | r_tx_flag);
      r_ac_clear  <= w_kbd & ((w_op == 3'd2) | (w_op == 3'd6));
      r_tx_pend   <= w_tx_pend_nxt;
      if (w_f1)      r_skip       <= w_skip_cond;
      if (w_rx_read) r_serial_bus <= {4'b0000, w_rx_head};

      if (w_rx_flush)     r_rx_overrun <= 1'b0;
      else if (w_rx_drop) r_rx_overrun <= 1'b1;

      if (clear | w_caf)                 r_int_ena <= 1'b1;
      else if (w_kbd & (w_op == 3'd5))   r_int_ena <= ac[11];

      if (clear | w_tx_set) r_tx_flag <= 1'b1;
      else if (w_tx_clr)    r_tx_flag <= 1'b0;
    end
  end

  assign serial_bus = r_serial_bus;
  assign ac_clear   = r_ac_clear;
  assign skip       = r_skip;
  assign interrupt  = r_interrupt;
  assign rx_overrun = r_rx_overrun;

endmodule
`default_nettype wire

// File: tb/tb_kl8e_fifo_console.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kl8e_fifo_console
//  Description : Self-checking bench for kl8e_fifo_console: directed console
//                scenarios followed by random traffic against a queue model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_kl8e_fifo_console;

  localparam logic [5:0] KBD  = 6'o03;
  localparam logic [5:0] TTY  = 6'o04;
  localparam int         RXD  = 8;
  localparam int         TXD  = 8;
  localparam logic [4:0] F1   = 5'd2;
  localparam logic [4:0] IDLE = 5'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:11] instruction;
  logic [4:0]  state;
  logic [0:11] ac;
  logic        UF, clear;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [0:11] serial_bus;
  logic        ac_clear, skip, interrupt, rx_overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [11:0] m_sbus;
  bit m_tx_flag, m_int_ena, m_pend, m_skip, m_acclr, m_int, m_ovr;

  kl8e_fifo_console #(
    .KBD_DEV(KBD), .TTY_DEV(TTY), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .F1_STATE(F1)
  ) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .state(state), .ac(ac),
    .UF(UF), .clear(clear), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .serial_bus(serial_bus), .ac_clear(ac_clear), .skip(skip),
    .interrupt(interrupt), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rxq.delete(); txq.delete();
    m_sbus = 12'h000; m_skip = 0; m_acclr = 0; m_int = 0; m_ovr = 0;
    m_tx_flag = 1; m_int_ena = 1; m_pend = 0;
  endtask

  // One clock edge of the console, computed from the rules on queues
  task automatic model_edge();
    bit kf, tf, f1, iot, kbd, tty, caf, deq, set, clr, pend_n, nint;
    logic [2:0] op;
    kf   = (rxq.size() != 0);
    tf   = m_tx_flag;
    nint = m_int_ena && (kf || tf);
    f1   = (state == F1);
    iot  = f1 && !UF && (instruction[0:2] == 3'o6);
    op   = instruction[9:11];
    kbd  = iot && (instruction[3:8] == KBD);
    tty  = iot && (instruction[3:8] == TTY);
    caf  = iot && (instruction == 12'o6007);
    if (clear) begin
      rxq.delete(); txq.delete();
      m_tx_flag = 1; m_int_ena = 1; m_ovr = 0; m_pend = 0; m_acclr = 0;
      if (f1) m_skip = 0;
    end else begin
      deq = (txq.size() != 0) && tx_ready;
      if (f1) m_skip = (kbd && op == 1 && kf) || (tty && op == 1 && tf) ||
                       (tty && op == 5 && m_int_ena && (kf || tf));
      m_acclr = kbd && (op == 2 || op == 6);
      if (kbd && (op == 4 || op == 6)) m_sbus = kf ? {4'h0, rxq[0]} : 12'h000;
      if (caf) begin
        rxq.delete(); m_ovr = 0;
      end else begin
        if (kbd && (op == 0 || op == 2 || op == 6) && kf) void'(rxq.pop_front());
        if (rx_valid) begin
          if (rxq.size() < RXD) rxq.push_back(rx_data);
          else m_ovr = 1;
        end
      end
      if (deq) void'(txq.pop_front());
      pend_n = 0;
      if (tty && (op == 4 || op == 6) && txq.size() < TXD) begin
        txq.push_back(ac[4:11]);
        pend_n = (txq.size() < TXD);
      end
      set = deq || m_pend || caf || (tty && op == 0);
      clr = tty && (op == 2 || op == 6);
      if (set) m_tx_flag = 1;
      else if (clr) m_tx_flag = 0;
      m_pend = pend_n;
      if (kbd && op == 5) m_int_ena = ac[11];
      if (caf) m_int_ena = 1;
    end
    m_int = nint;
  endtask

  task automatic check_all();
    check("serial_bus", serial_bus, m_sbus);
    check("skip", 12'(skip), 12'(m_skip));
    check("ac_clear", 12'(ac_clear), 12'(m_acclr));
    check("interrupt", 12'(interrupt), 12'(m_int));
    check("rx_overrun", 12'(rx_overrun), 12'(m_ovr));
    check("tx_valid", 12'(tx_valid), 12'(txq.size() != 0));
    if (txq.size() != 0) check("tx_data", 12'(tx_data), 12'(txq[0]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic iot(input logic [11:0] instr, input logic [11:0] acv);
    instruction = instr;
    ac          = acv;
    state       = F1;
    cycle();
    instruction = 12'o7000;
    state       = IDLE;
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; instruction = 12'o7000; state = IDLE; ac = 12'o0000;
    UF = 0; clear = 0; rx_data = 8'h00; rx_valid = 0; tx_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    reset = 1'b0;

    // Flags after reset
    cycle();
    check("int_after_reset", 12'(interrupt), 12'd1);
    iot(12'o6041, 12'o0000);
    check("tsf_reset", 12'(skip), 12'd1);
    iot(12'o6031, 12'o0000);
    check("ksf_empty", 12'(skip), 12'd0);

    // Keyboard receive and read-back
    rx_valid = 1; rx_data = 8'h41; cycle();
    rx_data = 8'h42; cycle();
    rx_valid = 0;
    iot(12'o6036, 12'o0000);
    check("krb1_data", serial_bus, 12'o0101);
    check("krb1_acclr", 12'(ac_clear), 12'd1);
    cycle();
    check("acclr_pulse", 12'(ac_clear), 12'd0);
    iot(12'o6031, 12'o0000);
    check("ksf_one_left", 12'(skip), 12'd1);
    iot(12'o6036, 12'o0000);
    check("krb2_data", serial_bus, 12'o0102);
    iot(12'o6031, 12'o0000);
    check("ksf_drained", 12'(skip), 12'd0);
    iot(12'o6036, 12'o0000);
    check("krb_empty", serial_bus, 12'o0000);

    // RX overrun and CAF
    rx_valid = 1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'h50 + 8'(i);
      cycle();
    end
    rx_valid = 0;
    check("overrun_set", 12'(rx_overrun), 12'd1);
    iot(12'o6034, 12'o0000);
    check("krs_head", serial_bus, 12'h050);
    iot(12'o6007, 12'o0000);
    check("caf_overrun", 12'(rx_overrun), 12'd0);
    iot(12'o6031, 12'o0000);
    check("caf_rx_empty", 12'(skip), 12'd0);

    // TX fill with the UART stalled, then drain
    tx_ready = 0;
    for (int i = 0; i < 10; i++) begin
      iot(12'o6046, 12'($urandom));
      cycle();
      iot(12'o6041, 12'o0000);
      check("tx_flag_after_push", 12'(skip), (i < 7) ? 12'd1 : 12'd0);
    end
    tx_ready = 1;
    repeat (8) cycle();
    check("tx_drained", 12'(tx_valid), 12'd0);
    tx_ready = 0;

    // User mode blocks every IOT
    rx_valid = 1; rx_data = 8'h77; cycle(); rx_valid = 0;
    UF = 1;
    iot(12'o6036, 12'o0000);
    check("uf_krb_acclr", 12'(ac_clear), 12'd0);
    iot(12'o6046, 12'o0123);
    check("uf_tls_txv", 12'(tx_valid), 12'd0);
    iot(12'o6035, 12'o0000);
    check("uf_kie_skip", 12'(skip), 12'd0);
    iot(12'o6031, 12'o0000);
    check("uf_ksf_skip", 12'(skip), 12'd0);
    UF = 0;

    // Interrupt enable off, then console clear
    iot(12'o6035, 12'o0000);
    iot(12'o6046, 12'o0252);
    cycle(); cycle();
    check("kie_off_int", 12'(interrupt), 12'd0);
    clear = 1; cycle(); clear = 0;
    check("clear_tx_flush", 12'(tx_valid), 12'd0);
    cycle();
    check("clear_int", 12'(interrupt), 12'd1);

    // Random traffic
    async_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [2:0] op;
      r  = $urandom_range(0, 9);
      op = 3'($urandom_range(0, 7));
      if (r < 4)       instruction = {3'o6, KBD, op};
      else if (r < 8)  instruction = {3'o6, TTY, op};
      else if (r == 8) instruction = 12'o6007;
      else             instruction = 12'($urandom);
      state    = ($urandom_range(0, 2) == 0) ? F1 : 5'($urandom_range(0, 31));
      UF       = ($urandom_range(0, 7) == 0);
      ac       = 12'($urandom);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      tx_ready = ($urandom_range(0, 3) == 0);
      clear    = ($urandom_range(0, 63) == 0);
      cycle();
      if (n == 1500) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
